// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: bit order and active-low glyph patterns.
package seg7_pkg;

    // Bit positions within the 7-bit segment bus (a is the MSB, g the LSB)
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Active-low patterns, ordered a..g
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;

endpackage

// File: rtl/seg7_decoder.sv
// BCD to active-low seven-segment decoder; codes 10..15 render dark.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Glyph lookup; non-decimal codes leave every segment off
    always_comb begin
        o_seg = SEG_OFF;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner: one digit per slot, most significant
// first, with a blanking gap at the start of every slot, leading-zero
// suppression, per-digit blink and registered active-low outputs.
module seven_segment_scanner
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int DEAD      = 8,
    parameter int BLINK_DIV = 250
) (
    input  logic                  clk_core,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [4*DIGITS-1:0]   bcd_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  blank_lz_i,
    input  logic [DIGITS-1:0]     blink_mask_i,
    output logic [DIGITS-1:0]     anode_o,
    output logic [6:0]            segment_o,
    output logic                  dp_o
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0]     r_presc;
    logic [IW-1:0]     r_idx;
    logic [BW-1:0]     r_bcnt;
    logic              r_phase;

    logic              w_tick;
    logic              w_dead;
    logic [3:0]        w_digit;
    logic              w_dp_sel;
    logic              w_blink_sel;
    logic              w_lz_sel;
    logic              w_run_zero;
    logic [DIGITS-1:0] w_lz_blank;
    logic              w_show;
    logic [6:0]        w_seg;

    assign w_tick = (r_presc == PW'(SCAN_DIV - 1));
    assign w_dead = (r_presc < PW'(DEAD));

    // Leading-zero mask: walk down from the MSD while every digit seen is zero
    always_comb begin
        w_lz_blank = '0;
        w_run_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_run_zero = w_run_zero & (bcd_i[4*k +: 4] == 4'd0);
            w_lz_blank[k] = w_run_zero & (k > 0);
        end
    end

    // Select the current digit's code and per-digit controls
    always_comb begin
        w_digit     = 4'd0;
        w_dp_sel    = 1'b0;
        w_blink_sel = 1'b0;
        w_lz_sel    = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_digit     = bcd_i[4*k +: 4];
                w_dp_sel    = dp_i[k];
                w_blink_sel = blink_mask_i[k];
                w_lz_sel    = w_lz_blank[k];
            end
        end
    end

    assign w_show = en_i & ~w_dead
                  & ~(blank_lz_i & w_lz_sel)
                  & ~(~r_phase & w_blink_sel);

    seg7_decoder u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    // Slot timing: prescaler, digit index and blink phase
    always_ff @(posedge clk_core) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= IW'(DIGITS - 1);
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= (r_idx == '0) ? IW'(DIGITS - 1) : r_idx - 1'b1;
                if (r_bcnt == BW'(BLINK_DIV - 1)) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Registered pin drive; a blanked digit releases its anode too
    always_ff @(posedge clk_core) begin
        if (!rst_n) begin
            anode_o   <= '1;
            segment_o <= SEG_OFF;
            dp_o      <= 1'b1;
        end else if (w_show) begin
            anode_o   <= ~(DIGITS'(1) << r_idx);
            segment_o <= w_seg;
            dp_o      <= ~w_dp_sel;
        end else begin
            anode_o   <= '1;
            segment_o <= SEG_OFF;
            dp_o      <= 1'b1;
        end
    end

endmodule
